// File: rtl/dot_product_acc.sv
// -----------------------------------------------------------------------------
// dot_product_acc
//
// Streaming signed dot-product engine. Operand pairs arrive over a valid/ready
// handshake, are multiplied by a combinational radix-4 Booth multiplier, and
// the 16-bit products are summed into a saturating signed accumulator. One
// result is produced per vector; a vector ends on in_last or when MAX_TERMS
// pairs have been accepted.
//
// Pipeline for a pair accepted at edge k:
//   k   : operands + effective-last registered (p1)
//   k+1 : product registered (p2)
//   k+2 : product added into the accumulator; on the last term the result
//         is published and out_valid rises
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand pair valid
//   in_ready     block can accept a pair this cycle (registered)
//   in_a, in_b   signed 8-bit operands
//   in_last      pair is the final term of the vector
//   out_valid    result valid (registered)
//   out_ready    consumer accepts the result
//   out_sum      signed ACC_W-bit dot-product result
//   out_count    number of terms accumulated into out_sum
//   out_overflow saturation occurred at least once during this vector
//
// Parameters:
//   ACC_W      accumulator/result width, 16..32
//   MAX_TERMS  maximum terms per vector, 1..255
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// booth_multiplier
//
// Combinational 8x8 signed multiplier using radix-4 Booth recoding. Four
// partial products, each selected from {0, +-a, +-2a} by an overlapping
// 3-bit window of b, are summed modulo 2^16; the full signed product range
// (-16256..16384) fits in 16 bits so the modular sum is exact.
//
// Ports:
//   a  signed multiplicand
//   b  signed multiplier
//   p  signed 16-bit product
// -----------------------------------------------------------------------------
module booth_multiplier (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] p
);

  // Partial product for one Booth digit, before positional shifting.
  function automatic logic signed [15:0] booth_pp(
    input logic [2:0]         code,
    input logic signed [15:0] mcand
  );
    logic signed [15:0] pp;
    pp = '0;
    case (code)
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand <<< 1;
      3'b100:         pp = -(mcand <<< 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  logic [8:0]         b_ext;   // b with the implicit b[-1] = 0 appended
  logic signed [15:0] a_ext;

  // NOTE: every variable written in always_comb gets a value on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    b_ext = {b, 1'b0};
    a_ext = {{8{a[7]}}, a};
    p     = booth_pp(b_ext[2:0], a_ext)
          + (booth_pp(b_ext[4:2], a_ext) <<< 2)
          + (booth_pp(b_ext[6:4], a_ext) <<< 4)
          + (booth_pp(b_ext[8:6], a_ext) <<< 6);
  end

endmodule

module dot_product_acc #(
  parameter int ACC_W     = 20,
  parameter int MAX_TERMS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_a,
  input  logic signed [7:0]       in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [7:0]              out_count,
  output logic                    out_overflow
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,  // accepting operand pairs
    FLUSH = 2'd1,  // last pair accepted, pipeline draining
    OUT   = 2'd2   // result presented, waiting for out_ready
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [7:0]              TERM_LIMIT = 8'(MAX_TERMS);

  state_t state;

  // Stage 1: registered operands
  logic               p1_valid;
  logic               p1_last;
  logic signed [7:0]  p1_a;
  logic signed [7:0]  p1_b;

  // Stage 2: registered product
  logic               p2_valid;
  logic               p2_last;
  logic signed [15:0] p2_prod;

  // Accumulation state for the vector in progress
  logic signed [ACC_W-1:0] acc;
  logic [7:0]              term_cnt;
  logic                    ovf_sticky;

  // Combinational helpers
  logic                    accept;
  logic [7:0]              cnt_next;
  logic                    eff_last;
  logic signed [15:0]      mult_p;
  logic [ACC_W:0]          sum_wide;
  logic                    clamp;
  logic signed [ACC_W-1:0] sum_sat;

  booth_multiplier u_mult (
    .a (p1_a),
    .b (p1_b),
    .p (mult_p)
  );

  always_comb begin
    accept   = in_valid && in_ready;
    cnt_next = term_cnt + 8'd1;
    // Reaching the term limit closes the vector even without in_last.
    eff_last = in_last || (cnt_next == TERM_LIMIT);

    // One guard bit: the two top bits disagree exactly when the true sum
    // left the ACC_W-bit signed range; the guard bit gives the direction.
    sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-15){p2_prod[15]}}, p2_prod};
    clamp    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    sum_sat  = sum_wide[ACC_W-1:0];
    if (clamp) begin
      sum_sat = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

  // NOTE: operand and product registers carry no reset; they are only
  // consumed when the matching valid bit is set, and those bits are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      p1_a <= in_a;
      p1_b <= in_b;
    end
    if (p1_valid) begin
      p2_prod <= mult_p;
    end
  end

  // Control, accumulation and registered outputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
      p1_valid     <= 1'b0;
      p1_last      <= 1'b0;
      p2_valid     <= 1'b0;
      p2_last      <= 1'b0;
      acc          <= '0;
      term_cnt     <= '0;
      ovf_sticky   <= 1'b0;
    end else begin
      // Valid/last bits advance every cycle alongside the data.
      p1_valid <= accept;
      p1_last  <= accept && eff_last;
      p2_valid <= p1_valid;
      p2_last  <= p1_valid && p1_last;

      if (accept) begin
        term_cnt <= cnt_next;
      end

      if (p2_valid) begin
        if (p2_last) begin
          // Publish and start the next vector from a clean slate. No pair
          // can be accepted on this edge (FLUSH), so the clears are safe.
          out_sum      <= sum_sat;
          out_count    <= term_cnt;
          out_overflow <= ovf_sticky || clamp;
          acc          <= '0;
          term_cnt     <= '0;
          ovf_sticky   <= 1'b0;
        end else begin
          acc        <= sum_sat;
          ovf_sticky <= ovf_sticky || clamp;
        end
      end

      case (state)
        ACCUM: begin
          if (accept && eff_last) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          if (p2_valid && p2_last) begin
            state     <= OUT;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_acc.sv
// -----------------------------------------------------------------------------
// tb_dot_product_acc
//
// Directed bench for dot_product_acc. Three instances share clk/rst:
//   inst 0 : ACC_W=20, MAX_TERMS=16 (defaults)
//   inst 1 : ACC_W=16, MAX_TERMS=16 (saturation)
//   inst 2 : ACC_W=20, MAX_TERMS=4  (implicit last)
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_dot_product_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              in_valid  [3];
  logic              in_last   [3];
  logic              out_ready [3];
  logic signed [7:0] in_a      [3];
  logic signed [7:0] in_b      [3];
  logic              in_ready_w  [3];
  logic              out_valid_w [3];
  logic [7:0]        out_count_w [3];
  logic              out_ovf_w   [3];

  logic signed [19:0] sum0;
  logic signed [15:0] sum1;
  logic signed [19:0] sum2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dot_product_acc #(.ACC_W(20), .MAX_TERMS(16)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]),
    .out_sum(sum0), .out_count(out_count_w[0]), .out_overflow(out_ovf_w[0])
  );

  dot_product_acc #(.ACC_W(16), .MAX_TERMS(16)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]),
    .out_sum(sum1), .out_count(out_count_w[1]), .out_overflow(out_ovf_w[1])
  );

  dot_product_acc #(.ACC_W(20), .MAX_TERMS(4)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_last(in_last[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready[2]),
    .out_sum(sum2), .out_count(out_count_w[2]), .out_overflow(out_ovf_w[2])
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] get_sum(input int s);
    case (s)
      0:       return {{12{sum0[19]}}, sum0};
      1:       return {{16{sum1[15]}}, sum1};
      default: return {{12{sum2[19]}}, sum2};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until accepted (bounded wait).
  task automatic send(input int s, input int a, input int b, input bit last);
    int guard;
    guard       = 0;
    in_valid[s] = 1'b1;
    in_a[s]     = 8'(a);
    in_b[s]     = 8'(b);
    in_last[s]  = last;
    while (!in_ready_w[s] && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("send_timeout", 32'(in_ready_w[s]), 1);
    step();
    in_valid[s] = 1'b0;
    in_last[s]  = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then compare the result fields.
  task automatic expect_result(input int s, input string tag, input int exp_sum,
                               input int exp_cnt, input bit exp_ovf);
    int guard;
    guard = 0;
    while (!out_valid_w[s] && guard < 20) begin
      step();
      guard++;
    end
    check({tag, "_valid"}, 32'(out_valid_w[s]), 1);
    check({tag, "_sum"},   get_sum(s), exp_sum);
    check({tag, "_count"}, 32'(out_count_w[s]), exp_cnt);
    check({tag, "_ovf"},   32'(out_ovf_w[s]), 32'(exp_ovf));
  endtask

  // One output handshake; block must be ready for input the next cycle.
  task automatic handshake(input int s, input string tag);
    out_ready[s] = 1'b1;
    step();
    out_ready[s] = 1'b0;
    check({tag, "_hs_valid"}, 32'(out_valid_w[s]), 0);
    check({tag, "_hs_ready"}, 32'(in_ready_w[s]), 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_last[i]   = 1'b0;
      out_ready[i] = 1'b0;
      in_a[i]      = '0;
      in_b[i]      = '0;
    end

    // Reset state on all instances
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready",  32'(in_ready_w[i]), 1);
      check("rst_out_valid", 32'(out_valid_w[i]), 0);
      check("rst_sum",       get_sum(i), 0);
      check("rst_count",     32'(out_count_w[i]), 0);
      check("rst_ovf",       32'(out_ovf_w[i]), 0);
    end

    // Back-to-back 3-term vector, out_ready held high: 12 - 30 - 56 = -74
    out_ready[0] = 1'b1;
    send(0, 3, 4, 0);
    check("v1_ready_mid", 32'(in_ready_w[0]), 1);
    send(0, -5, 6, 0);
    send(0, 7, -8, 1);
    check("v1_ready_k0", 32'(in_ready_w[0]), 0);
    check("v1_valid_k0", 32'(out_valid_w[0]), 0);
    step();
    check("v1_ready_k1", 32'(in_ready_w[0]), 0);
    check("v1_valid_k1", 32'(out_valid_w[0]), 0);
    step();
    check("v1_valid_k2", 32'(out_valid_w[0]), 1);
    check("v1_ready_k2", 32'(in_ready_w[0]), 0);
    check("v1_sum",      get_sum(0), -74);
    check("v1_count",    32'(out_count_w[0]), 3);
    check("v1_ovf",      32'(out_ovf_w[0]), 0);
    step();
    check("v1_hs_valid", 32'(out_valid_w[0]), 0);
    check("v1_hs_ready", 32'(in_ready_w[0]), 1);
    out_ready[0] = 1'b0;

    // Single-term product extremes
    send(0, -128, 127, 1);
    expect_result(0, "v2", -16256, 1, 0);
    handshake(0, "v2");
    send(0, -128, -128, 1);
    expect_result(0, "v3", 16384, 1, 0);
    handshake(0, "v3");

    // ACC_W=16 saturation: 4 x 16384 clamps at 32767; flag clears next vector
    send(1, -128, -128, 0);
    send(1, -128, -128, 0);
    send(1, -128, -128, 0);
    send(1, -128, -128, 1);
    expect_result(1, "sat", 32767, 4, 1);
    handshake(1, "sat");
    send(1, 1, 1, 1);
    expect_result(1, "sat_next", 1, 1, 0);
    handshake(1, "sat_next");

    // MAX_TERMS=4 implicit last, then the 5th pair starts a new vector
    send(2, 1, 2, 0);
    send(2, 1, 2, 0);
    send(2, 1, 2, 0);
    send(2, 1, 2, 0);
    check("mt_ready_after4", 32'(in_ready_w[2]), 0);
    expect_result(2, "mt4", 8, 4, 0);
    handshake(2, "mt4");
    send(2, 10, 10, 1);
    expect_result(2, "mt5", 100, 1, 0);
    handshake(2, "mt5");

    // Backpressure: result held for 5 cycles, input pulses ignored
    send(0, 2, 2, 1);
    expect_result(0, "bp", 4, 1, 0);
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1;
      in_a[0]     = 8'sd9;
      in_b[0]     = 8'sd9;
      in_last[0]  = 1'b1;
      step();
      check("bp_hold_valid", 32'(out_valid_w[0]), 1);
      check("bp_hold_ready", 32'(in_ready_w[0]), 0);
      check("bp_hold_sum",   get_sum(0), 4);
      check("bp_hold_count", 32'(out_count_w[0]), 1);
      check("bp_hold_ovf",   32'(out_ovf_w[0]), 0);
    end
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    handshake(0, "bp");
    check("bp_no_second", 32'(out_valid_w[0]), 0);
    send(0, 1, 1, 1);
    expect_result(0, "bp_next", 1, 1, 0);
    handshake(0, "bp_next");

    // Reset with partial sum 50 held and two pairs in flight
    send(0, 5, 10, 0);
    send(0, 1, 1, 0);
    send(0, 1, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", 32'(in_ready_w[0]), 1);
    check("mid_rst_valid", 32'(out_valid_w[0]), 0);
    check("mid_rst_sum",   get_sum(0), 0);
    check("mid_rst_count", 32'(out_count_w[0]), 0);
    check("mid_rst_ovf",   32'(out_ovf_w[0]), 0);
    step();
    step();
    step();
    check("mid_rst_quiet", 32'(out_valid_w[0]), 0);
    send(0, 2, 3, 1);
    expect_result(0, "post_rst", 6, 1, 0);
    handshake(0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_product_acc.md
Name: dot_product_acc

Overview:
- Sequential multiply-accumulate stage wrapped around the team's combinational 8x8 signed `booth_multiplier`.
- Accepts a stream of signed operand pairs through a valid/ready handshake and registers each pair into the multiplier.
- Registers each 16-bit product and accumulates the products into a saturating signed sum.
- Presents one dot-product result per vector, delimited by `in_last`, on a valid/ready output port.

Parameters:
- ACC_W, 20, accumulator and result width in bits (signed, two's complement); legal range 16..32.
- MAX_TERMS, 16, maximum terms per vector; reaching it forces an implicit last. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair this cycle
- in_a  input  8  signed multiplicand
- in_b  input  8  signed multiplier
- in_last  input  1  pair is the final term of the vector
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  ACC_W  signed dot-product result
- out_count  output  8  number of terms accumulated into out_sum
- out_overflow  output  1  saturation occurred at least once during this vector

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high; it is sampled only on a rising edge of `clk`.
- Reset values:
  - state=ACCUM; in_ready=1; out_valid=0.
  - out_sum=0, out_count=0, out_overflow=0.
  - Accumulator, term counter and sticky overflow cleared; all pipeline valid bits cleared.
- Accept: a pair is accepted on an edge where in_valid && in_ready. Data is ignored when in_valid=0.
- Pipeline, for a pair accepted at edge k:
  - k: in_a, in_b, in_last and forced-last are registered into operand regs (p1).
  - k+1: the multiplier output from the p1 operands is registered into the product reg (p2).
  - k+2: the product is sign-extended to ACC_W and added into the accumulator.
  - Throughput is 1 pair per cycle while in ACCUM.
- Saturation:
  - Accumulator update is acc + sext(prod), computed at ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1 it clamps to that value; if below -2^(ACC_W-1) it clamps to that value.
  - Any clamp sets the sticky overflow flag. Later terms keep adding from the clamped value.
- Term counter: increments on each accept. When an accepted pair brings the count to MAX_TERMS, that pair is treated as last even if in_last=0.
- States:
  - ACCUM: in_ready=1. Accepting an effective-last pair moves to FLUSH.
  - FLUSH: in_ready=0; the pipeline drains. At the edge where the last product is added (k+2):
    - out_sum takes the final accumulator value, out_count the term count, out_overflow the sticky flag.
    - out_valid is set to 1 and the state moves to OUT.
    - The accumulator, counter and sticky flag are cleared in the same edge.
  - OUT: in_ready=0. out_valid and all out_* fields hold stable until the edge where out_valid && out_ready. That edge clears out_valid and returns to ACCUM, so in_ready=1 in the next cycle.
- Latency: out_valid is 1 in the cycle following edge k+2, where k is the accept edge of the last pair.
- out_ready is ignored while out_valid=0.
- Reset mid-operation: rst overrides everything in that edge. In-flight pairs, the partial sum and any pending result are discarded, and no output handshake completes.
- Empty vector: impossible by construction, since every result has out_count >= 1.
- Arithmetic extremes: the product range is -16256..16384, and ACC_W >= 16 holds any single product exactly.

Test Plan:
- Pairs (3,4), (-5,6), (7,-8 last) back-to-back, out_ready=1 → out_valid 2 edges after the third accept; out_sum=-74, out_count=3, out_overflow=0; in_ready=0 from the edge after the last accept until the cycle after the output handshake.
- Single pair (-128,127,last) → out_sum=-16256, out_count=1; a second single pair (-128,-128,last) → out_sum=16384.
- ACC_W=16: four pairs (-128,-128), last on the 4th → out_sum=32767, out_overflow=1, out_count=4. The next vector (1,1,last) → out_sum=1, out_overflow=0 (sticky flag cleared per vector).
- MAX_TERMS=4: pairs (1,2),(1,2),(1,2),(1,2), all with in_last=0 → result out_sum=8, out_count=4 after the 4th pair. The 5th pair (10,10,last) forms a new vector → out_sum=100, out_count=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_sum, out_count and out_overflow stay stable, in_ready=0 throughout, and in_valid pulses are not accepted. out_ready=1 → one handshake, then in_ready=1 in the next cycle.
- Assert rst for one edge while 2 pairs are in flight and a partial sum of 50 is held → all outputs return to reset values. A following vector (2,3,last) yields out_sum=6, out_count=1.
